// File: rtl/fetch_unit_if.sv
// Fetch-side bundle: program-counter handshake, instruction-memory port and decode output.
// Combinational only; no storage, so no latency and no backpressure of its own.
// The decode stage pushes back through Hold, and memory gates progress through MemAck.
interface fetch_unit_if #(
    parameter int ADDR_W = 6
);
    logic [31:0]       PC;
    logic              Hold;
    logic              Flush;
    logic              en;
    logic              MemReq;
    logic [ADDR_W-1:0] MemAddr;
    logic              MemAck;
    logic [31:0]       MemData;
    logic [31:0]       Instr;
    logic              InstrValid;
    logic              Fault;

    modport slave (
        input  PC, Hold, Flush, MemAck, MemData,
        output en, MemReq, MemAddr, Instr, InstrValid, Fault
    );

    modport master (
        output PC, Hold, Flush, MemAck, MemData,
        input  en, MemReq, MemAddr, Instr, InstrValid, Fault
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch responder: latches the PC, requests one word, and hands it to decode.
// Latency: LATCH + N FETCH cycles + DONE, which is 3 cycles minimum per instruction.
// Backpressure: Hold parks the unit in DONE with Instr stable, and en advances the PC only on consumption.
module fetch_unit #(
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 15
) (
    input  logic         CLK,
    input  logic         Reset,
    fetch_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        LATCH = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       instr_q;

    logic latch_pc;
    logic capture;
    logic cnt_inc;
    logic req_c;
    logic valid_c;
    logic en_c;
    logic fault_c;

    // Upper PC bits alias by design; only the word index and alignment bits matter.
    logic unused_pc;
    assign unused_pc = ^bus.PC[31:ADDR_W+2];

    always_ff @(posedge CLK) begin
        if (Reset) state <= LATCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        latch_pc  = 1'b0;
        capture   = 1'b0;
        cnt_inc   = 1'b0;
        req_c     = 1'b0;
        valid_c   = 1'b0;
        en_c      = 1'b0;
        fault_c   = 1'b0;
        unique case (state)
            LATCH: begin
                latch_pc  = 1'b1;
                state_nxt = (bus.PC[1:0] != 2'b00) ? FAULT : FETCH;
            end
            FETCH: begin
                req_c = 1'b1;
                if (bus.Flush) begin
                    state_nxt = LATCH;
                end else if (bus.MemAck) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end else begin
                    // The counter stops at TIMEOUT because the unit leaves FETCH on that edge.
                    cnt_inc = 1'b1;
                    if (cnt == CNT_W'(TIMEOUT - 1)) state_nxt = FAULT;
                end
            end
            DONE: begin
                valid_c = 1'b1;
                en_c    = !bus.Hold && !bus.Flush;
                if (bus.Flush || !bus.Hold) state_nxt = LATCH;
            end
            FAULT: begin
                fault_c = 1'b1;
            end
            default: state_nxt = LATCH;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            addr_q  <= '0;
            instr_q <= '0;
            cnt     <= '0;
        end else begin
            if (latch_pc) begin
                addr_q <= bus.PC[ADDR_W+1:2];
                cnt    <= '0;
            end
            if (cnt_inc) cnt <= cnt + CNT_W'(1);
            if (capture) instr_q <= bus.MemData;
        end
    end

    assign bus.MemReq     = req_c;
    assign bus.MemAddr    = addr_q;
    assign bus.Instr      = instr_q;
    assign bus.InstrValid = valid_c;
    assign bus.en         = en_c;
    assign bus.Fault      = fault_c;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by a random run, checked cycle by cycle
// against a transaction-level reference model of the fetch behaviour.
module tb_fetch_unit;
    localparam int ADDR_W  = 6;
    localparam int TIMEOUT = 15;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] pc;
    logic [31:0] data;
    logic        hold, flush, ack;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: fault flag, request outstanding, instruction held for decode.
    bit          m_fault, m_busy, m_ready;
    int          m_wait;
    logic [5:0]  m_addr;
    logic [31:0] m_instr;
    logic [31:0] mem [64];

    fetch_unit_if #(.ADDR_W(ADDR_W)) ifc ();

    assign ifc.PC      = pc;
    assign ifc.Hold    = hold;
    assign ifc.Flush   = flush;
    assign ifc.MemAck  = ack;
    assign ifc.MemData = data;

    fetch_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (ifc)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check all outputs, advance the model and the PC.
    task automatic step(input bit r, input bit h, input bit f, input bit a);
        bit e_en;
        Reset = r;
        hold  = h;
        flush = f;
        ack   = a;
        data  = a ? mem[m_addr] : $urandom();
        e_en  = m_ready && !h && !f;
        #1;
        chk("en",         {31'd0, ifc.en},         {31'd0, e_en});
        chk("MemReq",     {31'd0, ifc.MemReq},     {31'd0, m_busy});
        chk("InstrValid", {31'd0, ifc.InstrValid}, {31'd0, m_ready});
        chk("Fault",      {31'd0, ifc.Fault},      {31'd0, m_fault});
        chk("MemAddr",    {26'd0, ifc.MemAddr},    {26'd0, m_addr});
        chk("Instr",      ifc.Instr,               m_instr);
        @(posedge CLK);
        @(negedge CLK);
        if (r) begin
            m_fault = 0; m_busy = 0; m_ready = 0; m_wait = 0;
            m_addr  = '0; m_instr = '0;
        end else if (m_fault) begin
            m_fault = 1;
        end else if (m_ready) begin
            if (f || !h) m_ready = 0;
        end else if (m_busy) begin
            if (f) begin
                m_busy = 0;
            end else if (a) begin
                m_instr = data;
                m_busy  = 0;
                m_ready = 1;
            end else begin
                m_wait++;
                if (m_wait == TIMEOUT) begin
                    m_busy  = 0;
                    m_fault = 1;
                end
            end
        end else begin
            m_addr = 6'((pc >> 2) % 64);
            m_wait = 0;
            if (pc % 4 != 0) m_fault = 1;
            else             m_busy  = 1;
        end
        if (!r && e_en) pc = pc + 32'd4;
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < 64; i++) mem[i] = $urandom();
        mem[0] = 32'h2008_0005;
        pc = 32'd0; hold = 0; flush = 0; ack = 0; data = '0; Reset = 1'b1;
        m_fault = 0; m_busy = 0; m_ready = 0; m_wait = 0; m_addr = '0; m_instr = '0;
        repeat (3) @(negedge CLK);

        // Reset state
        step(1, 0, 0, 0);

        // Basic fetch: LATCH at PC 0, ack on the first FETCH cycle
        step(0, 0, 0, 0);
        chk("basic_addr", {26'd0, ifc.MemAddr}, 32'd0);
        chk("basic_req",  {31'd0, ifc.MemReq},  32'd1);
        step(0, 0, 0, 1);
        chk("basic_instr", ifc.Instr, 32'h2008_0005);
        chk("basic_valid", {31'd0, ifc.InstrValid}, 32'd1);
        chk("basic_req_drop", {31'd0, ifc.MemReq}, 32'd0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("basic_next_addr", {26'd0, ifc.MemAddr}, 32'd1);

        // Hold for four cycles in DONE, then release
        step(0, 0, 0, 1);
        repeat (4) step(0, 1, 0, 0);
        chk("hold_instr", ifc.Instr, mem[1]);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);

        // Flush coinciding with MemAck, redirect to 0x70
        pc = 32'h70;
        step(0, 0, 1, 1);
        chk("flush_valid", {31'd0, ifc.InstrValid}, 32'd0);
        chk("flush_instr", ifc.Instr, mem[1]);
        step(0, 0, 0, 0);
        chk("flush_addr", {26'd0, ifc.MemAddr}, 32'd28);

        // Misaligned PC faults and stays faulted
        step(0, 0, 1, 0);
        pc = 32'h6;
        step(0, 0, 0, 0);
        chk("mis_fault", {31'd0, ifc.Fault},  32'd1);
        chk("mis_req",   {31'd0, ifc.MemReq}, 32'd0);
        repeat (6) step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        chk("mis_sticky", {31'd0, ifc.Fault}, 32'd1);
        pc = 32'h10;
        step(1, 0, 0, 0);
        chk("mis_rst_fault", {31'd0, ifc.Fault},      32'd0);
        chk("mis_rst_valid", {31'd0, ifc.InstrValid}, 32'd0);
        chk("mis_rst_instr", ifc.Instr,               32'd0);

        // Timeout: no ack for TIMEOUT cycles
        step(0, 0, 0, 0);
        cnt = 0;
        repeat (TIMEOUT + 5) begin
            if (ifc.MemReq === 1'b1) cnt++;
            step(0, 0, 0, 0);
        end
        chk("timeout_req_cycles", cnt, TIMEOUT);
        chk("timeout_fault", {31'd0, ifc.Fault}, 32'd1);

        // Ack on the TIMEOUT-th cycle is still accepted
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        repeat (TIMEOUT - 1) step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("late_ack_valid", {31'd0, ifc.InstrValid}, 32'd1);
        chk("late_ack_fault", {31'd0, ifc.Fault},      32'd0);
        chk("late_ack_instr", ifc.Instr, mem[4]);

        // Reset mid-FETCH, with a stray ack two cycles later
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_req_drop", {31'd0, ifc.MemReq}, 32'd0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        chk("rst_ack_instr", ifc.Instr, 32'd0);
        chk("rst_ack_valid", {31'd0, ifc.InstrValid}, 32'd0);

        // Random traffic
        pc = 32'h40;
        for (int i = 0; i < 800; i++) begin
            bit r, h, f, a;
            r = m_fault ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 199) == 0);
            h = ($urandom_range(0, 2) == 0);
            f = ($urandom_range(0, 9) == 0);
            a = m_busy ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
            if (f) begin
                pc = $urandom() & 32'hFFFF_FFFC;
                if ($urandom_range(0, 49) == 0) pc = pc | 32'd2;
            end
            step(r, h, f, a);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
